// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
// Module : alu_sequencer_pkg
// Brief  : Opcode encodings, FSM states and decode bundle for alu_sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_sequencer_pkg;

    localparam int OPC_W = 4;
    localparam int OPR_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_LD  = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_XOR = 4'h6,
        OP_NOT = 4'h7,
        OP_ST  = 4'h8,
        OP_JMP = 4'h9,
        OP_JZ  = 4'hA,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    typedef struct packed {
        logic alu_op;
        logic cy_op;
        logic store;
        logic jump;
        logic jump_cond;
        logic halt;
    } decode_t;

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_if.sv
// ============================================================================
// Module : alu_sequencer_if
// Brief  : Program-memory, ALU and register-file control bundle of the sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface alu_sequencer_if #(
    parameter int OPCODE_WIDTH  = 4,
    parameter int OPERAND_WIDTH = 4,
    parameter int PC_WIDTH      = 4
);
    logic                                  start;
    logic [PC_WIDTH-1:0]                   prog_addr;
    logic                                  prog_req;
    logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] prog_data;
    logic                                  prog_valid;
    logic                                  acc_zero;
    logic [OPCODE_WIDTH-1:0]               opcode;
    logic                                  alu_ce;
    logic                                  cy_ce;
    logic [OPERAND_WIDTH-1:0]              reg_addr;
    logic                                  reg_we;
    logic                                  busy;
    logic                                  halted;

    modport master (
        input  start, prog_data, prog_valid, acc_zero,
        output prog_addr, prog_req, opcode, alu_ce, cy_ce,
               reg_addr, reg_we, busy, halted
    );

    modport slave (
        output start, prog_data, prog_valid, acc_zero,
        input  prog_addr, prog_req, opcode, alu_ce, cy_ce,
               reg_addr, reg_we, busy, halted
    );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer_instr_decoder.sv
// ============================================================================
// Module : alu_sequencer_instr_decoder
// Brief  : Combinational opcode to control-class decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_sequencer_instr_decoder
    import alu_sequencer_pkg::*;
(
    input  wire logic [OPC_W-1:0] op,
    output decode_t               dec
);

    always_comb begin
        dec = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                dec.alu_op = 1'b1;
                dec.cy_op  = 1'b1;
            end
            OP_LD, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                dec.alu_op = 1'b1;
            end
            OP_ST:  dec.store = 1'b1;
            OP_JMP: dec.jump  = 1'b1;
            OP_JZ: begin
                dec.jump      = 1'b1;
                dec.jump_cond = 1'b1;
            end
            OP_HLT: dec.halt = 1'b1;
            // NOP and the unassigned codes B..E fall through with no strobes
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module : alu_sequencer
// Brief  : Fetch/decode/execute control unit for the 8-bit accumulator datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int OPCODE_WIDTH  = OPC_W,
    parameter int OPERAND_WIDTH = OPR_W,
    parameter int PC_WIDTH      = OPR_W
) (
    input  wire logic        clk,
    input  wire logic        reset,
    alu_sequencer_if.master  bus
);

    localparam int IR_W = OPCODE_WIDTH + OPERAND_WIDTH;
    localparam logic [PC_WIDTH-1:0] C_PC_ONE = 1;

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [PC_WIDTH-1:0]      w_pc_nxt;
    logic [IR_W-1:0]          r_ir;
    logic [IR_W-1:0]          w_ir_nxt;

    logic [OPCODE_WIDTH-1:0]  w_ir_op;
    logic [OPERAND_WIDTH-1:0] w_ir_operand;
    decode_t                  w_dec;

    logic w_prog_req;
    logic w_alu_ce;
    logic w_cy_ce;
    logic w_reg_we;
    logic w_busy;
    logic w_halted;

    assign w_ir_op      = r_ir[IR_W-1:OPERAND_WIDTH];
    assign w_ir_operand = r_ir[OPERAND_WIDTH-1:0];

    alu_sequencer_instr_decoder u_decoder (
        .op  (w_ir_op),
        .dec (w_dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_prog_req  = 1'b0;
        w_alu_ce    = 1'b0;
        w_cy_ce     = 1'b0;
        w_reg_we    = 1'b0;
        w_busy      = 1'b0;
        w_halted    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_busy     = 1'b1;
                w_prog_req = 1'b1;
                if (bus.prog_valid) begin
                    w_ir_nxt    = bus.prog_data;
                    w_pc_nxt    = r_pc + C_PC_ONE;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_busy      = 1'b1;
                w_state_nxt = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                w_busy   = 1'b1;
                w_alu_ce = w_dec.alu_op;
                w_cy_ce  = w_dec.cy_op;
                w_reg_we = w_dec.store;
                // PC already points past this instruction; a taken jump overrides it
                if (w_dec.jump && (!w_dec.jump_cond || bus.acc_zero))
                    w_pc_nxt = w_ir_operand;
                w_state_nxt = w_dec.halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                w_halted = 1'b1;
                if (bus.start) w_state_nxt = ST_FETCH;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.prog_addr = r_pc;
    assign bus.prog_req  = w_prog_req;
    assign bus.opcode    = w_ir_op;
    assign bus.reg_addr  = w_ir_operand;
    assign bus.alu_ce    = w_alu_ce;
    assign bus.cy_ce     = w_cy_ce;
    assign bus.reg_we    = w_reg_we;
    assign bus.busy      = w_busy;
    assign bus.halted    = w_halted;

    a_excl_strobe: assert property (@(posedge clk) disable iff (reset)
        !(w_alu_ce && w_reg_we));
    a_cy_implies_alu: assert property (@(posedge clk) disable iff (reset)
        w_cy_ce |-> w_alu_ce);

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module : tb_alu_sequencer
// Brief  : Instruction-level reference model bench for alu_sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_sequencer_if #(.OPCODE_WIDTH(4), .OPERAND_WIDTH(4), .PC_WIDTH(4)) bus ();

    alu_sequencer #(.OPCODE_WIDTH(4), .OPERAND_WIDTH(4), .PC_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rom [16];
    logic [3:0] m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},    bus.prog_req, 1'b0);
        check({tag, "_busy"},   bus.busy, 1'b0);
        check({tag, "_halted"}, bus.halted, 1'b0);
        check({tag, "_strb"},   {bus.alu_ce, bus.cy_ce, bus.reg_we}, 3'b000);
        check({tag, "_addr"},   bus.prog_addr, 4'h0);
        check({tag, "_opc"},    bus.opcode, 4'h0);
        check({tag, "_rega"},   bus.reg_addr, 4'h0);
    endtask

    task automatic do_reset();
        bus.start      = 1'b0;
        bus.prog_valid = 1'b0;
        bus.prog_data  = 8'h00;
        bus.acc_zero   = 1'b0;
        reset          = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_pc  = 4'h0;
        tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // One instruction from its first FETCH cycle; az_mode: -1 random, else forced.
    task automatic run_instr(input int waits, input int az_mode, output bit hlt);
        logic [3:0] op;
        logic [3:0] opr;
        bit         az;
        bit         e_alu;
        bit         e_cy;
        bit         e_we;
        check("fetch_req",  bus.prog_req, 1'b1);
        check("fetch_addr", bus.prog_addr, m_pc);
        check("fetch_busy", bus.busy, 1'b1);
        for (int w = 0; w < waits; w++) begin
            bus.prog_valid = 1'b0;
            bus.prog_data  = 8'($urandom);
            bus.start      = 1'($urandom_range(0, 1));
            tick();
            check("wait_req",  bus.prog_req, 1'b1);
            check("wait_addr", bus.prog_addr, m_pc);
            check("wait_strb", {bus.alu_ce, bus.cy_ce, bus.reg_we}, 3'b000);
        end
        bus.start      = 1'($urandom_range(0, 1));
        bus.prog_valid = 1'b1;
        bus.prog_data  = rom[m_pc];
        op             = rom[m_pc][7:4];
        opr            = rom[m_pc][3:0];
        tick();
        m_pc = m_pc + 4'h1;

        bus.prog_valid = 1'b0;
        bus.prog_data  = 8'($urandom);
        check("dec_req",  bus.prog_req, 1'b0);
        check("dec_busy", bus.busy, 1'b1);
        check("dec_opc",  bus.opcode, op);
        check("dec_rega", bus.reg_addr, opr);
        check("dec_strb", {bus.alu_ce, bus.cy_ce, bus.reg_we}, 3'b000);
        az           = (az_mode < 0) ? 1'($urandom_range(0, 1)) : (az_mode != 0);
        bus.acc_zero = az;
        bus.start    = 1'($urandom_range(0, 1));
        tick();

        e_alu = (op >= 4'h1) && (op <= 4'h7);
        e_cy  = (op == 4'h1) || (op == 4'h2);
        e_we  = (op == 4'h8);
        check("exe_strb", {bus.alu_ce, bus.cy_ce, bus.reg_we}, {e_alu, e_cy, e_we});
        check("exe_opc",  bus.opcode, op);
        check("exe_rega", bus.reg_addr, opr);
        check("exe_req",  bus.prog_req, 1'b0);
        if (op == 4'h9 || (op == 4'hA && az)) m_pc = opr;
        hlt       = (op == 4'hF);
        bus.start = 1'($urandom_range(0, 1));
        tick();
        bus.start = 1'b0;
        if (hlt) begin
            check("halt_flag", bus.halted, 1'b1);
            check("halt_busy", bus.busy, 1'b0);
            check("halt_pc",   bus.prog_addr, m_pc);
            tick();
            check("halt_hold", {bus.halted, bus.prog_addr}, {1'b1, m_pc});
        end
    endtask

    task automatic run_prog(input int n, input int waits, input int az_mode);
        bit h;
        for (int i = 0; i < n; i++) begin
            run_instr(waits, az_mode, h);
            if (h && i != n - 1) pulse_start();
        end
    endtask

    initial begin
        bit h;
        do_reset();
        check_idle_outputs("rst");

        // LD 3, ADD 4, ST 5, HLT with zero-wait ROM
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h33; rom[1] = 8'h14; rom[2] = 8'h85; rom[3] = 8'hF0;
        pulse_start();
        run_prog(4, 0, -1);
        check("prog1_pc", bus.prog_addr, 4'h4);

        // resume from HALT with two wait cycles per fetch
        rom[4] = 8'h27; rom[5] = 8'h8A; rom[6] = 8'hF0;
        pulse_start();
        run_prog(3, 2, -1);

        // JZ taken / not taken at address 2
        for (int az = 1; az >= 0; az--) begin
            do_reset();
            for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
            rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'hA7;
            pulse_start();
            run_prog(3, 0, az);
            check("jz_target", bus.prog_addr, (az != 0) ? 4'h7 : 4'h3);
            run_instr(0, -1, h);
        end

        // PC wrap via JMP F then NOP at F
        do_reset();
        for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
        rom[0] = 8'h9F; rom[15] = 8'h00; rom[0] = 8'h9F;
        pulse_start();
        run_prog(2, 0, -1);
        check("wrap_addr", bus.prog_addr, 4'h0);

        // undefined opcode C, then halt
        do_reset();
        rom[0] = 8'hC5; rom[1] = 8'hF0;
        pulse_start();
        run_prog(2, 1, -1);

        // randomized program, resuming each time it halts
        do_reset();
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        pulse_start();
        for (int n = 0; n < 150; n++) begin
            run_instr($urandom_range(0, 2), -1, h);
            if (h) pulse_start();
        end

        // asynchronous reset in the middle of a fetch
        if (bus.prog_addr == 4'h0) begin
            rom[m_pc] = 8'h00;
            run_instr(0, -1, h);
        end
        check("pre_rst_req", bus.prog_req, 1'b1);
        bus.prog_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("midrst");
        tick();
        reset = 1'b0;
        m_pc  = 4'h0;
        tick();
        check_idle_outputs("postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1);
    end

endmodule

`default_nettype wire
